// File: rtl/sbox_round_sched.sv
// sbox_round_sched: drives a single sbox instance through NROUNDS passes per
// transaction. A state is accepted on a valid/ready input, pushed through the
// sbox once per round (restart, wait for done, capture cout), and the final
// state is presented on a valid/ready output. A pass that never completes
// within MAX_WAIT cycles ends the transaction with out_err set.
//
// Optional feature: define SBOX_ROUND_CONST_EN to XOR the round index into
// bits [7:0] of the sbox input before every pass. Without the macro the sbox
// input is the raw captured state.

module sbox_round_sched #(
  parameter int CWIDTH   = 320,
  parameter int NROUNDS  = 12,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] out_data,
  output logic              out_err,
  output logic [CWIDTH-1:0] sb_c,
  output logic              sb_reset,
  input  logic [CWIDTH-1:0] sb_cout,
  input  logic              sb_done,
  output logic              busy
);

  // Round counter only has to reach NROUNDS-1; keep at least one bit.
  localparam int RW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;
  // Wait counter carries one spare bit above what MAX_WAIT-1 needs.
  localparam int WW = $clog2(MAX_WAIT) + 1;

  localparam logic [RW-1:0] ROUND_LAST = RW'(NROUNDS - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    OUT     = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [CWIDTH-1:0] state_reg;
  logic [RW-1:0]     round;
  logic [WW-1:0]     wait_cnt;

  // Per-cycle control strobes decoded from the FSM.
  logic              accept;
  logic              do_load;
  logic              do_run;
  logic              do_timeout;
  logic              do_capture;
  logic              last_round;

  // Ungated handshake/control outputs; reset gating is applied afterwards.
  logic              in_ready_c;
  logic              out_valid_c;
  logic              sb_reset_c;

  assign last_round = (round == ROUND_LAST);

  // FSM state register; reset always lands in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the strobes that steer the datapath registers.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    do_load     = 1'b0;
    do_run      = 1'b0;
    do_timeout  = 1'b0;
    do_capture  = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    sb_reset_c  = 1'b0;

    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = LOAD;
        end
      end

      LOAD: begin
        // Hold the sbox in restart for one cycle so its done flag is clear
        // before the pass begins.
        sb_reset_c = 1'b1;
        do_load    = 1'b1;
        next_state = RUN;
      end

      RUN: begin
        do_run = 1'b1;
        // A done in the same cycle as the deadline still counts as success.
        if (sb_done) begin
          next_state = CAPTURE;
        end else if (wait_cnt == WAIT_LAST) begin
          do_timeout = 1'b1;
          next_state = OUT;
        end
      end

      CAPTURE: begin
        do_capture = 1'b1;
        if (last_round) begin
          next_state = OUT;
        end else begin
          next_state = LOAD;
        end
      end

      OUT: begin
        out_valid_c = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath registers: captured state, round index, pass timer, error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= '0;
      round     <= '0;
      wait_cnt  <= '0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        state_reg <= in_data;
        round     <= '0;
        out_err   <= 1'b0;
      end

      if (do_load) begin
        wait_cnt <= '0;
      end

      if (do_run) begin
        wait_cnt <= wait_cnt + WW'(1);
      end

      if (do_timeout) begin
        out_err <= 1'b1;
      end

      // The final round leaves round at NROUNDS-1; it is cleared on the
      // next accept.
      if (do_capture) begin
        state_reg <= sb_cout;
        if (!last_round) begin
          round <= round + RW'(1);
        end
      end
    end
  end

  // Handshake outputs are forced inactive while reset is asserted, and the
  // sbox is held in restart for the whole reset so it never runs on stale data.
  assign in_ready  = reset & in_ready_c;
  assign out_valid = reset & out_valid_c;
  assign busy      = reset & (state != IDLE);
  assign sb_reset  = ~reset | sb_reset_c;
  assign out_data  = state_reg;

  // sb_c only changes on accept and capture, so it stays put across LOAD and
  // RUN while the sbox is sampling it.
`ifdef SBOX_ROUND_CONST_EN
  assign sb_c = state_reg ^ {{(CWIDTH-8){1'b0}}, 8'(round)};
`else
  assign sb_c = state_reg;
`endif

  // Result and error flag must not move while the consumer is stalling.
  a_out_hold: assert property (
    @(posedge clk) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_err))
  );

  // The sbox samples c for the whole pass, so it must not change during RUN.
  a_sb_c_stable: assert property (
    @(posedge clk) disable iff (!reset)
    (state == RUN) |-> $stable(sb_c)
  );

  // Accepting a new state while a transaction is in flight is never allowed.
  a_ready_busy: assert property (
    @(posedge clk) disable iff (!reset)
    !(in_ready && busy)
  );

endmodule
